// File: rtl/itch_fixed_msg_decoder_if.sv
// One-byte-per-cycle ITCH stream shared by every decoder in the parser fabric.
// The framer drives the master side and each per-type decoder listens on the slave side.
interface itch_fixed_msg_decoder_if;
    logic [7:0] byte_in;
    logic       valid_in;

    modport master (output byte_in, output valid_in);
    modport slave  (input  byte_in, input  valid_in);
endinterface

// File: rtl/itch_fixed_msg_decoder.sv
// Streaming decoder for a single fixed-length ITCH message type. It captures the payload
// big-endian, skips foreign messages by their table length and aborts truncated ones.
module itch_fixed_msg_decoder #(
    parameter logic [7:0] MSG_TYPE    = 8'h44,
    parameter int         MSG_LENGTH  = 9,
    parameter int         GAP_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    itch_fixed_msg_decoder_if.slave       stream,
    output logic                          decoded_valid,
    output logic [8*(MSG_LENGTH-1)-1:0]   decoded_payload,
    output logic                          packet_invalid,
    output logic [1:0]                    error_code,
    output logic [15:0]                   msg_count
);

    localparam int IDX_W = $clog2(MSG_LENGTH);
    localparam int GAP_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LENGTH - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SKIP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [5:0]       skip_cnt;

    logic [GAP_W-1:0] gap_next;
    logic             gap_expired;

    // Bytes still to skip after the type byte of a foreign message.
    function automatic logic [5:0] skip_init(input logic [7:0] msg_type);
        case (msg_type)
            8'h41:   return 6'd35;  // 'A'
            8'h58:   return 6'd22;  // 'X'
            8'h55:   return 6'd26;  // 'U'
            8'h44:   return 6'd8;   // 'D'
            8'h45:   return 6'd29;  // 'E'
            8'h50:   return 6'd39;  // 'P'
            default: return 6'd1;
        endcase
    endfunction

    assign gap_next    = gap_cnt + GAP_W'(1);
    assign gap_expired = (GAP_TIMEOUT != 0) && (gap_next == GAP_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            gap_cnt         <= '0;
            skip_cnt        <= '0;
            decoded_valid   <= 1'b0;
            // NOTE: the payload is a flat output register with a defined reset value, not a
            // storage array, so it is reset along with the rest of the state.
            decoded_payload <= '0;
            packet_invalid  <= 1'b0;
            error_code      <= 2'b00;
            msg_count       <= '0;
        end else begin
            // NOTE: pulse defaults come first; a later non-blocking assignment in the same
            // block overrides them, so each pulse lasts exactly one cycle.
            decoded_valid  <= 1'b0;
            packet_invalid <= 1'b0;
            error_code     <= 2'b00;

            case (state)
                IDLE: begin
                    if (stream.valid_in) begin
                        gap_cnt <= '0;
                        if (stream.byte_in == MSG_TYPE) begin
                            state           <= CAPTURE;
                            idx             <= IDX_W'(1);
                            decoded_payload <= '0;
                        end else begin
                            state    <= SKIP;
                            skip_cnt <= skip_init(stream.byte_in);
                        end
                    end
                end

                CAPTURE: begin
                    if (stream.valid_in) begin
                        gap_cnt <= '0;
                        // Slot idx lands big-endian: byte 1 in the MSBs, last byte in [7:0].
                        for (int i = 1; i < MSG_LENGTH; i++) begin
                            if (idx == IDX_W'(i))
                                decoded_payload[8*(MSG_LENGTH-1-i) +: 8] <= stream.byte_in;
                        end
                        if (idx == IDX_LAST) begin
                            state         <= IDLE;
                            decoded_valid <= 1'b1;
                            msg_count     <= msg_count + 16'd1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (gap_expired) begin
                        state           <= IDLE;
                        packet_invalid  <= 1'b1;
                        error_code      <= 2'b01;
                        decoded_payload <= '0;
                    end else if (GAP_TIMEOUT != 0) begin
                        gap_cnt <= gap_next;
                    end
                end

                SKIP: begin
                    if (stream.valid_in) begin
                        gap_cnt <= '0;
                        if (skip_cnt == 6'd1) state <= IDLE;
                        skip_cnt <= skip_cnt - 6'd1;
                    end else if (gap_expired) begin
                        state          <= IDLE;
                        packet_invalid <= 1'b1;
                        error_code     <= 2'b10;
                    end else if (GAP_TIMEOUT != 0) begin
                        gap_cnt <= gap_next;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_itch_fixed_msg_decoder.sv
// Self-checking bench: message-level stimulus with an expected-event queue derived from
// ITCH message lengths, payload bytes and gap lengths.
module tb_itch_fixed_msg_decoder;

    localparam logic [7:0] TYPE_D = 8'h44;
    localparam int         LEN    = 9;
    localparam int         GAP    = 4;

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [1:0]  err;
        logic [63:0] payload;
        logic [15:0] count;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        decoded_valid;
    logic [63:0] decoded_payload;
    logic        packet_invalid;
    logic [1:0]  error_code;
    logic [15:0] msg_count;

    itch_fixed_msg_decoder_if bus ();

    itch_fixed_msg_decoder #(
        .MSG_TYPE    (TYPE_D),
        .MSG_LENGTH  (LEN),
        .GAP_TIMEOUT (GAP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stream          (bus),
        .decoded_valid   (decoded_valid),
        .decoded_payload (decoded_payload),
        .packet_invalid  (packet_invalid),
        .error_code      (error_code),
        .msg_count       (msg_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    ev_t         exp_q[$];
    logic [15:0] exp_count   = '0;
    logic [63:0] exp_payload = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int itch_len(input logic [7:0] t);
        case (t)
            8'h41:   return 36;
            8'h58:   return 23;
            8'h55:   return 27;
            8'h44:   return 9;
            8'h45:   return 30;
            8'h50:   return 40;
            default: return 2;
        endcase
    endfunction

    // Compare the outputs seen after each edge against the expected event queue.
    task automatic sample();
        ev_t e;
        if (decoded_valid || packet_invalid) begin
            check("pulse_exclusive", 64'(decoded_valid & packet_invalid), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {62'd0, decoded_valid, packet_invalid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", 64'(cyc), 64'(e.cyc));
                check("event_kind", 64'(packet_invalid), 64'(e.is_err));
                if (e.is_err) check("error_code", 64'(error_code), 64'(e.err));
                check("payload", decoded_payload, e.payload);
                check("msg_count", 64'(msg_count), 64'(e.count));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            check("missed_event", 64'(decoded_valid | packet_invalid), 64'd1);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic put(input logic v, input logic [7:0] b);
        bus.valid_in = v;
        bus.byte_in  = b;
        @(posedge clk);
        #1;
        cyc++;
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 8'($urandom));
    endtask

    // Send the first n_sent bytes of one message; fewer than its length means truncation.
    task automatic send_msg(input logic [7:0] mtype, input int n_sent, input bit counting,
                            input bit rand_gaps, input int gap_pos, input int gap_len);
        int          len;
        bit          is_d;
        bit          full;
        logic [7:0]  msg[$];
        logic [63:0] pl;
        ev_t         e;
        len  = itch_len(mtype);
        is_d = (mtype == TYPE_D);
        full = (n_sent >= len);
        msg.push_back(mtype);
        for (int i = 1; i < len; i++) begin
            logic [7:0] b;
            b = counting ? 8'(i) : 8'($urandom);
            if (!is_d && (i == 1 || $urandom_range(0, 3) == 0)) b = TYPE_D;
            msg.push_back(b);
        end
        pl = '0;
        if (is_d) for (int i = 1; i < len; i++) pl = {pl[55:0], msg[i]};

        for (int i = 0; i < len && i < n_sent; i++) begin
            if (i > 0 && i == gap_pos) idle(gap_len);
            else if (i > 0 && rand_gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, GAP - 1));
            if (is_d && full && i == len - 1) begin
                exp_count++;
                exp_payload = pl;
                e.cyc = cyc + 1; e.is_err = 1'b0; e.err = 2'b00;
                e.payload = pl; e.count = exp_count;
                exp_q.push_back(e);
            end
            put(1'b1, msg[i]);
        end

        if (!full) begin
            if (is_d) exp_payload = '0;
            e.cyc = cyc + GAP; e.is_err = 1'b1; e.err = is_d ? 2'b01 : 2'b10;
            e.payload = exp_payload; e.count = exp_count;
            exp_q.push_back(e);
            idle(GAP);
        end
    endtask

    function automatic logic [7:0] pick_type();
        logic [7:0] t;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return TYPE_D;
            4:          return 8'h41;
            5:          return 8'h58;
            6:          return 8'h55;
            7:          return 8'h45;
            8:          return 8'h50;
            default: begin
                do t = 8'($urandom); while (itch_len(t) != 2);
                return t;
            end
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.byte_in  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_decoded_valid", 64'(decoded_valid), 64'd0);
        check("reset_packet_invalid", 64'(packet_invalid), 64'd0);
        check("reset_error_code", 64'(error_code), 64'd0);
        check("reset_payload", decoded_payload, 64'd0);
        check("reset_msg_count", 64'(msg_count), 64'd0);
        rst = 1'b0;
        idle(2);

        // Contiguous 'D' 01..08, then the payload must hold.
        send_msg(TYPE_D, LEN, 1'b1, 1'b0, -1, 0);
        idle(3);
        check("hold_payload", decoded_payload, 64'h0102030405060708);
        check("count_after_first", 64'(msg_count), 64'd1);

        // Two back-to-back 'D' messages.
        send_msg(TYPE_D, LEN, 1'b0, 1'b0, -1, 0);
        send_msg(TYPE_D, LEN, 1'b0, 1'b0, -1, 0);
        check("count_after_b2b", 64'(msg_count), 64'd3);

        // 'X' carrying 0x44 bytes, then 'D'.
        send_msg(8'h58, 23, 1'b0, 1'b0, -1, 0);
        send_msg(TYPE_D, LEN, 1'b0, 1'b0, -1, 0);

        // 'D' plus 4 bytes then timeout, then a full 'D'.
        send_msg(TYPE_D, 5, 1'b0, 1'b0, -1, 0);
        send_msg(TYPE_D, LEN, 1'b0, 1'b0, -1, 0);

        // 'D' plus 3 bytes, tolerated 3-cycle gap, 5 more bytes.
        send_msg(TYPE_D, LEN, 1'b0, 1'b0, 4, 3);

        // Unknown type with one trailing byte, then 'D'.
        send_msg(8'h5A, 2, 1'b0, 1'b0, -1, 0);
        send_msg(TYPE_D, LEN, 1'b0, 1'b0, -1, 0);
        idle(2);

        // Reset mid-capture.
        put(1'b1, TYPE_D);
        put(1'b1, 8'($urandom));
        put(1'b1, 8'($urandom));
        bus.valid_in = 1'b1;
        bus.byte_in  = 8'($urandom);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        exp_count   = '0;
        exp_payload = '0;
        check("rst_mid_decoded_valid", 64'(decoded_valid), 64'd0);
        check("rst_mid_packet_invalid", 64'(packet_invalid), 64'd0);
        check("rst_mid_error_code", 64'(error_code), 64'd0);
        check("rst_mid_payload", decoded_payload, 64'd0);
        check("rst_mid_msg_count", 64'(msg_count), 64'd0);
        idle(12);

        // Randomised mix of types, in-message gaps, truncations and inter-message idles.
        for (int m = 0; m < 300; m++) begin
            logic [7:0] t;
            int         len;
            int         n;
            t   = pick_type();
            len = itch_len(t);
            n   = ($urandom_range(0, 9) < 7) ? len : $urandom_range(1, len - 1);
            send_msg(t, n, 1'b0, 1'b1, -1, 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
        end
        idle(GAP + 2);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_msg_count", 64'(msg_count), 64'(exp_count));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
